// File: rtl/lcd_refresh.sv
// HD44780 16x2 refresh engine: initialises the panel, then streams a 32-byte character RAM to it forever.
// Define LCD_REFRESH_PWRUP_EN to include the power-on delay state; without it reset enters INIT directly.
module lcd_refresh #(
  parameter int SETUP_CYC      = 2,
  parameter int EN_CYC         = 12,
  parameter int WAIT_CYC       = 2500,
  parameter int CLEAR_WAIT_CYC = 100000,
  parameter int PWRUP_CYC      = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [4:0] raddr,
  input  logic [7:0] din,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       lcd_blon,
  output logic       frame_done
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, EN_CYC), max2(WAIT_CYC, CLEAR_WAIT_CYC)), PWRUP_CYC);
  localparam int CW      = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {PWRUP, INIT, ADDR, FETCH, CHAR} state_t;
  // PH_LOAD is the single cycle after reset that loads the first init command.
  typedef enum logic [1:0] {PH_LOAD, PH_SETUP, PH_STROBE, PH_WAIT} phase_t;

  state_t          state_reg, state_next;
  phase_t          phase_reg, phase_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1:0]      init_idx_reg, init_idx_next;
  logic [4:0]      raddr_reg, raddr_next;
  logic [7:0]      data_reg, data_next;
  logic            rs_reg, rs_next;
  logic            fd_reg, fd_next;
  logic            write_done;
  logic [CW-1:0]   wait_last;
  logic [4:0]      raddr_inc;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef LCD_REFRESH_PWRUP_EN
      state_reg <= PWRUP;
`else
      state_reg <= INIT;
`endif
      phase_reg    <= PH_LOAD;
      cnt_reg      <= '0;
      init_idx_reg <= '0;
      raddr_reg    <= '0;
      data_reg     <= 8'h00;
      rs_reg       <= 1'b0;
      fd_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      cnt_reg      <= cnt_next;
      init_idx_reg <= init_idx_next;
      raddr_reg    <= raddr_next;
      data_reg     <= data_next;
      rs_reg       <= rs_next;
      fd_reg       <= fd_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    cnt_next      = cnt_reg + 1'b1;
    init_idx_next = init_idx_reg;
    raddr_next    = raddr_reg;
    data_next     = data_reg;
    rs_next       = rs_reg;
    fd_next       = 1'b0;
    write_done    = 1'b0;
    raddr_inc     = raddr_reg + 5'd1;
    // The clear command needs the long settle time.
    wait_last     = (!rs_reg && data_reg == 8'h01) ? CW'(CLEAR_WAIT_CYC - 1) : CW'(WAIT_CYC - 1);

    case (state_reg)
`ifdef LCD_REFRESH_PWRUP_EN
      PWRUP: begin
        if (cnt_reg == CW'(PWRUP_CYC - 1)) begin
          state_next    = INIT;
          phase_next    = PH_SETUP;
          cnt_next      = '0;
          init_idx_next = 2'd0;
          data_next     = init_cmd(2'd0);
          rs_next       = 1'b0;
        end
      end
`endif
      FETCH: begin
        data_next  = din;
        rs_next    = 1'b1;
        state_next = CHAR;
        phase_next = PH_SETUP;
        cnt_next   = '0;
      end
      default: begin
        case (phase_reg)
          PH_LOAD: begin
            data_next  = init_cmd(init_idx_reg);
            rs_next    = 1'b0;
            phase_next = PH_SETUP;
            cnt_next   = '0;
          end
          PH_SETUP: if (cnt_reg == CW'(SETUP_CYC - 1)) begin
            phase_next = PH_STROBE;
            cnt_next   = '0;
          end
          PH_STROBE: if (cnt_reg == CW'(EN_CYC - 1)) begin
            phase_next = PH_WAIT;
            cnt_next   = '0;
          end
          default: if (cnt_reg == wait_last) write_done = 1'b1;
        endcase

        // New command bytes are loaded on the same edge that enters SETUP.
        if (write_done) begin
          phase_next = PH_SETUP;
          cnt_next   = '0;
          case (state_reg)
            INIT: begin
              if (init_idx_reg == 2'd3) begin
                state_next = ADDR;
                data_next  = {1'b1, raddr_reg[4], 6'b0};
              end else begin
                init_idx_next = init_idx_reg + 2'd1;
                data_next     = init_cmd(init_idx_reg + 2'd1);
              end
              rs_next = 1'b0;
            end
            ADDR: state_next = FETCH;
            default: begin
              raddr_next = raddr_inc;
              fd_next    = (raddr_reg == 5'h1F);
              if (raddr_inc[3:0] == 4'h0) begin
                state_next = ADDR;
                data_next  = {1'b1, raddr_inc[4], 6'b0};
                rs_next    = 1'b0;
              end else begin
                state_next = FETCH;
              end
            end
          endcase
        end
      end
    endcase
  end

  assign raddr      = raddr_reg;
  assign lcd_data   = data_reg;
  assign lcd_rs     = rs_reg;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = (phase_reg == PH_STROBE);
  assign lcd_on     = 1'b1;
  assign lcd_blon   = 1'b1;
  assign frame_done = fd_reg;

endmodule

// File: tb/tb_lcd_refresh.sv
// Directed bench for lcd_refresh: records every enable strobe and compares it against a hand-built table.
module tb_lcd_refresh;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] raddr;
  logic [7:0] din;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, frame_done;

  logic [7:0] mem [32];
  assign din = mem[raddr];

  always #5 clk = ~clk;

`ifdef LCD_REFRESH_PWRUP_EN
  localparam int FIRST_GAP = 52;
`else
  localparam int FIRST_GAP = 3;
`endif
  localparam int NVEC = 72;

  lcd_refresh #(
    .SETUP_CYC(2), .EN_CYC(4), .WAIT_CYC(8), .CLEAR_WAIT_CYC(20), .PWRUP_CYC(50)
  ) dut (
    .clk(clk), .reset(reset), .raddr(raddr), .din(din), .lcd_data(lcd_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on),
    .lcd_blon(lcd_blon), .frame_done(frame_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         gap;
    int         hi;
  } vec_t;
  vec_t tbl [NVEC];
  int   nt = 0;

  task automatic push(input logic [7:0] d, input logic r, input int g);
    tbl[nt].data = d;
    tbl[nt].rs   = r;
    tbl[nt].gap  = g;
    tbl[nt].hi   = 4;
    nt++;
  endtask

  // Strobe recorder
  logic [7:0] s_data  [128];
  logic       s_rs    [128];
  int         s_gap   [128];
  int         s_setup [128];
  int         s_hi    [128];
  bit         s_unst  [128];
  int         n = 0;
  int         fd_cnt = 0;
  int         fd_n     [4];
  int         fd_raddr [4];
  bit         fd_wide = 0;
  int         low_cnt = 0, setup_cnt = 0;
  logic       prev_en = 0, prev_rs = 0, prev_fd = 0;
  logic [7:0] prev_data = 8'h00;

  initial forever begin
    @(negedge clk);
    if (lcd_en) begin
      if (!prev_en) begin
        if (n < 128) begin
          s_data[n] = lcd_data; s_rs[n] = lcd_rs; s_gap[n] = low_cnt;
          s_setup[n] = setup_cnt; s_hi[n] = 1; s_unst[n] = 0;
        end
        n++;
      end else if (n >= 1 && n <= 128) begin
        s_hi[n-1]++;
        if (lcd_data != prev_data || lcd_rs != prev_rs) s_unst[n-1] = 1;
      end
      low_cnt = 0;
    end else begin
      low_cnt++;
      if (prev_en || lcd_data != prev_data || lcd_rs != prev_rs) setup_cnt = 1;
      else setup_cnt++;
    end
    if (reset) begin
      low_cnt = 0;
      setup_cnt = 0;
    end
    if (frame_done) begin
      if (prev_fd) fd_wide = 1;
      if (fd_cnt < 4) begin
        fd_n[fd_cnt] = n;
        fd_raddr[fd_cnt] = int'(raddr);
      end
      fd_cnt++;
    end
    prev_en = lcd_en; prev_rs = lcd_rs; prev_data = lcd_data; prev_fd = frame_done;
  end

  initial begin
    string l1, l2;
    logic [7:0] pd;
    logic       pr;
    int         exp_setup, k;
    bit         done;

    l1 = "Hello";
    l2 = "World";
    for (int a = 0; a < 32; a++) mem[a] = 8'h20;
    for (int i = 0; i < 5; i++) begin
      mem[i]      = l1[i];
      mem[16 + i] = l2[i];
    end

    // Expected strobes: init, frame 1, then frame 2 with 0x12 replaced by 'X'.
    push(8'h38, 0, FIRST_GAP);
    push(8'h0C, 0, 10);
    push(8'h01, 0, 10);
    push(8'h06, 0, 22);
    push(8'h80, 0, 10);
    for (int f = 0; f < 2; f++) begin
      if (f == 1) push(8'h80, 0, 10);
      for (int a = 0; a < 32; a++) begin
        if (a == 16) push(8'hC0, 0, 10);
        if (f == 1 && a == 18) push(8'h58, 1, 11);
        else push(mem[a], 1, 11);
      end
    end

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_data", int'(lcd_data), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_en", int'(lcd_en), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_rw", int'(lcd_rw), 0);
    chk("rst_on", int'(lcd_on), 1);
    chk("rst_blon", int'(lcd_blon), 1);
    reset = 1'b0;

    done = 0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      if (fd_cnt == 1 && raddr == 5'h05) begin
        mem[5'h12] = 8'h58;
        done = 1;
      end
    end
    chk("ram_update_trigger", int'(done), 1);

    for (int c = 0; c < 20000 && n < NVEC + 1; c++) @(negedge clk);
    chk("strobe_count_reached", int'(n >= NVEC + 1), 1);

    pd = 8'h00;
    pr = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      exp_setup = (tbl[i].data == pd && tbl[i].rs == pr) ? tbl[i].gap : 2;
      $display("vec %0d: data=%02h rs=%0d gap=%0d hi=%0d setup=%0d", i, s_data[i], s_rs[i],
               s_gap[i], s_hi[i], s_setup[i]);
      chk($sformatf("v%0d_data", i), int'(s_data[i]), int'(tbl[i].data));
      chk($sformatf("v%0d_rs", i), int'(s_rs[i]), int'(tbl[i].rs));
      chk($sformatf("v%0d_gap", i), s_gap[i], tbl[i].gap);
      chk($sformatf("v%0d_hi", i), s_hi[i], tbl[i].hi);
      chk($sformatf("v%0d_setup", i), s_setup[i], exp_setup);
      chk($sformatf("v%0d_stable", i), int'(s_unst[i]), 0);
      pd = tbl[i].data;
      pr = tbl[i].rs;
    end

    $display("frame_done: count=%0d at strobes %0d,%0d", fd_cnt, fd_n[0], fd_n[1]);
    chk("fd_count", fd_cnt, 2);
    chk("fd0_after_strobe", fd_n[0], 38);
    chk("fd1_after_strobe", fd_n[1], 72);
    chk("fd0_raddr", fd_raddr[0], 0);
    chk("fd1_raddr", fd_raddr[1], 0);
    chk("fd_one_cycle", int'(fd_wide), 0);

    // Reset in the middle of an enable pulse.
    chk("pre_reset_en_high", int'(lcd_en), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_en_drop", int'(lcd_en), 0);
    chk("reset_raddr", int'(raddr), 0);
    chk("reset_data", int'(lcd_data), 0);
    k = n;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 2000 && n <= k; c++) @(negedge clk);
    chk("post_reset_strobe_seen", int'(n > k), 1);
    $display("post-reset strobe: data=%02h rs=%0d gap=%0d setup=%0d", s_data[k], s_rs[k], s_gap[k], s_setup[k]);
    chk("post_reset_data", int'(s_data[k]), 8'h38);
    chk("post_reset_rs", int'(s_rs[k]), 0);
    chk("post_reset_gap", s_gap[k], FIRST_GAP);
    chk("post_reset_setup", s_setup[k], 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_refresh.md
LCD_REFRESH -- requirements
Module: lcd_refresh

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, meaning clocks lcd_rs/lcd_data are stable before lcd_en rises.
REQ-002 SHALL have parameter EN_CYC, default 12, meaning clocks lcd_en is held high per bus write.
REQ-003 SHALL have parameter WAIT_CYC, default 2500, meaning clocks idle after each write with lcd_en low (≥40 us at 50 MHz).
REQ-004 SHALL have parameter CLEAR_WAIT_CYC, default 100000, meaning idle clocks after the clear command 0x01.
REQ-005 SHALL have parameter PWRUP_CYC, default 1000000, meaning the power-on delay in clocks.
REQ-006 SHALL use a single clock; reset is synchronous and active-high.
REQ-007 clk  input  1  rising-edge system clock.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 raddr  output  5  character RAM read address; 0x00-0x0F is line 1, 0x10-0x1F is line 2.
REQ-010 din  input  8  character code from the RAM's combinational read port for raddr.
REQ-011 lcd_data  output  8  HD44780 data bus.
REQ-012 lcd_rs  output  1  0 = command, 1 = character data.
REQ-013 lcd_rw  output  1  tied 0 (write only).
REQ-014 lcd_en  output  1  HD44780 enable strobe.
REQ-015 lcd_on  output  1  panel power, constant 1.
REQ-016 lcd_blon  output  1  backlight, constant 1.
REQ-017 frame_done  output  1  one-cycle pulse after character 0x1F is written.

Function
REQ-018 FSM states SHALL be PWRUP, INIT, ADDR, FETCH, CHAR.
REQ-019 Every bus write SHALL run the same phases in order: SETUP (SETUP_CYC clocks, en=0), STROBE (EN_CYC clocks, en=1), WAIT (WAIT_CYC clocks, or CLEAR_WAIT_CYC after 0x01, en=0).
REQ-020 lcd_data and lcd_rs SHALL stay constant from the start of SETUP through the end of WAIT.
REQ-021 PWRUP SHALL idle PWRUP_CYC clocks, then go to INIT.
REQ-022 INIT SHALL issue commands (rs=0) 0x38, 0x0C, 0x01, 0x06 in that order, then go to ADDR.
REQ-023 ADDR SHALL issue command 0x80 when raddr[4]=0 or 0xC0 when raddr[4]=1, then go to FETCH.
REQ-024 FETCH SHALL last exactly 1 clock with raddr stable and en=0; lcd_data<=din and lcd_rs<=1 SHALL be registered at its end.
REQ-025 CHAR SHALL perform one data write of the fetched byte, then increment raddr mod 32.
REQ-026 After CHAR, the FSM SHALL go to ADDR if the new raddr[3:0]==0, else to FETCH.
REQ-027 Frames SHALL repeat indefinitely with no INIT re-run: 0x1F wraps to 0x00, followed by ADDR 0x80.
REQ-028 frame_done SHALL assert on the clock raddr wraps from 0x1F to 0x00.
REQ-029 din SHALL be sampled only in FETCH; RAM writes during a frame appear when that address is next fetched.
REQ-030 All phase counters SHALL be wide enough for the largest parameter; the terminal count is N-1.

Reset
REQ-031 On reset the outputs SHALL be: raddr=0, lcd_data=0x00, lcd_rs=0, lcd_en=0, frame_done=0, state=PWRUP, counters=0; lcd_rw=0, lcd_on=1, lcd_blon=1.
REQ-032 Reset asserted mid-write SHALL drive lcd_en=0 on the next clock and restart from PWRUP (or INIT per REQ-034).

Configuration
REQ-033 Macro LCD_REFRESH_PWRUP_EN defined: the PWRUP state is present per REQ-021.
REQ-034 Macro LCD_REFRESH_PWRUP_EN undefined: PWRUP is omitted, reset enters INIT directly, and PWRUP_CYC is ignored (simulation builds).

Verification (SETUP_CYC=2, EN_CYC=4, WAIT_CYC=8, CLEAR_WAIT_CYC=20, PWRUP_CYC=50)
REQ-035 Reset release with macro defined -> lcd_en stays 0 for 50 clocks, then the first strobe has lcd_data=0x38, rs=0, high exactly 4 clocks, 2 clocks after data setup.
REQ-036 Init sequence -> strobes carry 0x38, 0x0C, 0x01, 0x06, 0x80; the gap after 0x01 is 20 idle clocks and 8 after the others.
REQ-037 RAM holds "Hello" / "World" -> the rs=1 strobes read H,e,l,l,o, then 11 spaces, then command 0xC0, then W,o,r,l,d, then 11 spaces.
REQ-038 End of frame -> frame_done pulses 1 clock as raddr goes 0x1F->0x00, the next strobe is 0x80 with rs=0, and no INIT commands repeat.
REQ-039 RAM address 0x12 changed to "X" while raddr=0x05 -> that frame's 0x12 strobe carries 0x58.
REQ-040 Reset asserted during an en=1 phase -> lcd_en=0 the following clock, and with the macro undefined the next strobe is 0x38 after 2 setup clocks.
